// File: rtl/serial_alu_ctrl.sv
// Bit-serial XOR/AND/OR/ADD sequencer driving one 1-bit gate slice, LSB first.
// Define SERIAL_ALU_SUB_EN to build the inverter/carry-preset path for OP=100 (A-B).
module serial_alu_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] Y,
  output logic             COUT
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } state_e;

  typedef enum logic [2:0] {
    OP_XOR = 3'b000,
    OP_AND = 3'b001,
    OP_OR  = 3'b010,
    OP_ADD = 3'b011,
    OP_SUB = 3'b100
  } op_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] res_sr;
  logic [WIDTH-1:0] res_full;
  logic [2:0]       op_q;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             last_bit;

  logic a_bit, b_bit, x_bit, g_bit, p_bit, sum_bit, carry_next, res_bit, arith;

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign res_full = {res_bit, res_sr};

  // One-bit slice: the gate outputs are shared by the logic ops and the adder.
  always_comb begin
    a_bit = a_sr[0];
    b_bit = b_sr[0];
`ifdef SERIAL_ALU_SUB_EN
    if (op_q == OP_SUB) b_bit = ~b_sr[0];
`endif
    x_bit      = a_bit ^ b_bit;
    g_bit      = a_bit & b_bit;
    p_bit      = a_bit | b_bit;
    sum_bit    = x_bit ^ carry;
    carry_next = g_bit | (carry & x_bit);
    res_bit    = 1'b0;
    arith      = 1'b0;
    case (op_q)
      OP_XOR: res_bit = x_bit;
      OP_AND: res_bit = g_bit;
      OP_OR:  res_bit = p_bit;
      OP_ADD: begin
        res_bit = sum_bit;
        arith   = 1'b1;
      end
`ifdef SERIAL_ALU_SUB_EN
      OP_SUB: begin
        res_bit = sum_bit;
        arith   = 1'b1;
      end
`endif
      default: begin
        res_bit = 1'b0;
        arith   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (START) state_d = RUN;
      RUN:     if (last_bit) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign BUSY = (state_q == RUN);
  assign DONE = (state_q == FIN);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      op_q   <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      Y      <= '0;
      COUT   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (START) begin
            a_sr  <= A;
            b_sr  <= B;
            op_q  <= OP;
            cnt   <= '0;
`ifdef SERIAL_ALU_SUB_EN
            carry <= (OP == OP_SUB);
`else
            carry <= 1'b0;
`endif
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_full[WIDTH-1:1];
          carry  <= carry_next;
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            Y    <= res_full;
            COUT <= arith & carry_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/serial_alu_ctrl.md
# serial_alu_ctrl

Bit-serial ALU sequencer that drives one shared 1-bit gate slice (xor_gate, and_gate, or_gate) across WIDTH-bit operands, LSB first, one bit per clock. The slice is built from the team's gate primitives. It sits between the CPU control path and the gate library, and gives the CPU a multi-bit XOR/AND/OR/ADD from single-bit hardware. The block uses a START/BUSY/DONE handshake.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32
- CLK  input  1  rising-edge clock
- RST_N  input  1  synchronous, active-low reset
- START  input  1  request pulse or level; sampled only in IDLE
- OP  input  3  operation code: 000 XOR, 001 AND, 010 OR, 011 ADD, 100 SUB (macro-gated)
- A  input  WIDTH  operand A; sampled with START
- B  input  WIDTH  operand B; sampled with START
- BUSY  output  1  high while bits are being processed
- DONE  output  1  one-cycle completion strobe
- Y  output  WIDTH  result register; held until the next completion
- COUT  output  1  final carry for ADD/SUB; 0 for logic ops
- Clocking: one clock; reset is synchronous and active-low.

## Operation
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - START=1 at an edge latches A, B and OP into shift registers.
  - Clears the bit counter.
  - Sets carry to 0 (1 for SUB).
  - Next state RUN.
- RUN, each edge:
  - Slice computes on operand bit[0]. XOR/AND/OR: single gate. ADD: sum = a^b^c, carry = (a&b)|(c&(a^b)). SUB: ADD with b inverted.
  - Result bit shifts into the MSB of the result shift register. Operand registers shift right.
  - Carry flop updates; counter increments.
  - On the edge that processes bit WIDTH-1: Y <= final result, COUT <= final carry (forced 0 for logic ops), next state FIN.
- FIN: DONE=1 for exactly one cycle; next state IDLE unconditionally.
- START is ignored in RUN and FIN. There is no queuing; the requester must re-assert START in IDLE.
- Unsupported OP codes run the full sequence and complete with Y=0, COUT=0.
- Arithmetic is modulo 2^WIDTH. COUT for SUB is the no-borrow flag: 1 when A>=B unsigned.
- Reset (RST_N=0 at any edge, including mid-RUN):
  - State IDLE, BUSY=0, DONE=0, Y=0, COUT=0.
  - Counter, carry and shift registers cleared.
  - An in-flight operation is aborted and produces no DONE.
- RST_N=0 and START=1 at the same edge: reset wins.

## Timing
- Edge 0 samples START in IDLE. BUSY=1 from after edge 0 through edge WIDTH.
- Edges 1..WIDTH process bits 0..WIDTH-1.
- After edge WIDTH: DONE=1, BUSY=0, Y and COUT valid.
- After edge WIDTH+1: IDLE, DONE=0.
- Earliest next START acceptance is edge WIDTH+2. Throughput is WIDTH+2 cycles per operation.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Y and COUT change only at the completion edge or at reset.

## Configuration
- Macro: SERIAL_ALU_SUB_EN.
- Defined: OP=100 performs A-B. The slice inverts the B bit through the gate-built inverter and the carry is preset to 1.
- Undefined: no inverter or carry-preset logic is built. OP=100 is treated as unsupported (Y=0, COUT=0). All other timing is identical.

## Test plan
- Reset, then XOR: WIDTH=8, OP=000, A=0xA5, B=0x3C, START one cycle -> BUSY high 8 cycles, DONE one cycle at edge 8, Y=0x99, COUT=0.
- AND/OR back-to-back: A=0xF0, B=0x3C -> AND gives Y=0x30; OR issued at the first IDLE cycle gives Y=0xFC. Y holds 0x30 until the second DONE.
- ADD wrap: A=0xFF, B=0x01, OP=011 -> Y=0x00, COUT=1. Then A=0x12, B=0x34 -> Y=0x46, COUT=0.
- SUB (macro defined): A=0x10, B=0x01 -> Y=0x0F, COUT=1. A=0x00, B=0x01 -> Y=0xFF, COUT=0. Macro undefined: OP=100 -> Y=0x00, COUT=0.
- START while busy: START held high during RUN with A=0x00 -> ignored. The first result is unaffected, and the held START is accepted at the first IDLE edge.
- Reset mid-run: RST_N=0 at the 3rd RUN edge -> next cycle BUSY=0, Y=0, COUT=0. No DONE appears in the following 20 cycles.
